knn_topk_vote: RTL and testbench

//  Downstream consumer of the squared-Euclidean distance stage. Accepts one (distance, label) pair per

---
 rtl/knn_topk_vote.sv | 184 ++++++++++++++++++
 tb/tb_knn_topk_vote.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_vote.sv
// k-nearest-neighbour back end: keeps the K smallest (distance, label) pairs of a query in a
// sorted list, then runs a majority vote over the retained labels and reports the winning class.
module knn_topk_vote #(
  parameter int WIDTH   = 4,
  parameter int K       = 3,
  parameter int LABEL_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [2*WIDTH-1:0]     dist_i,
  input  logic [LABEL_W-1:0]     label_i,
  input  logic                   last_i,
  input  logic                   valid_i,
  output logic                   yumi_o,
  output logic                   valid_o,
  input  logic                   yumi_i,
  output logic [LABEL_W-1:0]     class_o,
  output logic [2*WIDTH-1:0]     min_dist_o,
  output logic [$clog2(K+1)-1:0] count_o
);

  localparam int DIST_W      = 2 * WIDTH;
  localparam int NUM_CLASSES = 2 ** LABEL_W;
  localparam int CW          = $clog2(K + 1);
  localparam int IW          = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_VOTE,
    S_PICK,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [DIST_W-1:0]    r_dist  [K];
  logic [LABEL_W-1:0]   r_label [K];
  logic [K-1:0]         r_vld;

  logic [CW-1:0]        r_cnt   [NUM_CLASSES];
  logic [IW-1:0]        r_vidx;

  logic                 r_valid;
  logic [LABEL_W-1:0]   r_class;
  logic [DIST_W-1:0]    r_min;
  logic [CW-1:0]        r_count;

  logic                 w_accept;
  logic                 w_release;
  logic [K-1:0]         w_lt;
  logic [K-1:0]         w_shift;
  logic [DIST_W-1:0]    w_up_dist  [K];
  logic [LABEL_W-1:0]   w_up_label [K];
  logic [K-1:0]         w_up_vld;

  logic [LABEL_W-1:0]   w_best_cls;
  logic [CW-1:0]        w_best_cnt;
  logic [CW-1:0]        w_used;

  assign w_accept  = valid_i && (r_state == S_COLLECT);
  assign w_release = (r_state == S_DONE) && r_valid && yumi_i;
  assign yumi_o    = w_accept;

  assign valid_o    = r_valid;
  assign class_o    = r_class;
  assign min_dist_o = r_min;
  assign count_o    = r_count;

  // Valid slots always form a sorted prefix, so w_lt is a thermometer code: its first set bit is
  // the insertion point and every later set bit takes its upper neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_slot
      assign w_lt[gi] = !r_vld[gi] || (dist_i < r_dist[gi]);

      if (gi == 0) begin : g_head
        assign w_shift[gi]    = 1'b0;
        assign w_up_dist[gi]  = '0;
        assign w_up_label[gi] = '0;
        assign w_up_vld[gi]   = 1'b0;
      end else begin : g_tail
        assign w_shift[gi]    = w_lt[gi-1];
        assign w_up_dist[gi]  = r_dist[gi-1];
        assign w_up_label[gi] = r_label[gi-1];
        assign w_up_vld[gi]   = r_vld[gi-1];
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_vld[gi]   <= 1'b0;
          r_dist[gi]  <= '0;
          r_label[gi] <= '0;
        end else if (w_release) begin
          r_vld[gi] <= 1'b0;
        end else if (w_accept && w_lt[gi]) begin
          if (w_shift[gi]) begin
            r_vld[gi]   <= w_up_vld[gi];
            r_dist[gi]  <= w_up_dist[gi];
            r_label[gi] <= w_up_label[gi];
          end else begin
            r_vld[gi]   <= 1'b1;
            r_dist[gi]  <= dist_i;
            r_label[gi] <= label_i;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COLLECT: if (w_accept && last_i) w_state_next = S_VOTE;
      S_VOTE:    if (r_vidx == IW'(K - 1)) w_state_next = S_PICK;
      S_PICK:    w_state_next = S_DONE;
      S_DONE:    if (w_release) w_state_next = S_COLLECT;
      default:   w_state_next = S_COLLECT;
    endcase
  end

  // One slot is tallied per cycle so only a single counter increment exists in hardware.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vidx <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
    end else if (w_accept && last_i) begin
      r_vidx <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
    end else if (r_state == S_VOTE) begin
      r_vidx <= r_vidx + 1'b1;
      if (r_vld[r_vidx]) r_cnt[r_label[r_vidx]] <= r_cnt[r_label[r_vidx]] + 1'b1;
    end
  end

  // Strict comparison while scanning upward leaves the lowest label on a count tie.
  always_comb begin
    w_best_cls = '0;
    w_best_cnt = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (r_cnt[c] > w_best_cnt) begin
        w_best_cnt = r_cnt[c];
        w_best_cls = LABEL_W'(c);
      end
    end
  end

  always_comb begin
    w_used = '0;
    for (int i = 0; i < K; i++) w_used = w_used + CW'(r_vld[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_class <= '0;
      r_min   <= '0;
      r_count <= '0;
    end else if (r_state == S_PICK) begin
      r_class <= w_best_cls;
      r_min   <= r_dist[0];
      r_count <= w_used;
    end
  end

  // Result becomes visible one cycle after entering S_DONE, giving the K+2 cycle latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_valid <= !w_release;
    end else begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Directed bench for knn_topk_vote (K=3): table of whole queries plus hand-written sequences
// for back-pressure, asynchronous reset during the vote and the tie/drop corner cases.
module tb_knn_topk_vote;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] dist_i;
  logic [1:0] label_i;
  logic       last_i;
  logic       valid_i;
  logic       yumi_o;
  logic       valid_o;
  logic       yumi_i;
  logic [1:0] class_o;
  logic [7:0] min_dist_o;
  logic [1:0] count_o;

  int n_vec = 0;
  int n_err = 0;

  knn_topk_vote #(.WIDTH(4), .K(3), .LABEL_W(2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .dist_i     (dist_i),
    .label_i    (label_i),
    .last_i     (last_i),
    .valid_i    (valid_i),
    .yumi_o     (yumi_o),
    .valid_o    (valid_o),
    .yumi_i     (yumi_i),
    .class_o    (class_o),
    .min_dist_o (min_dist_o),
    .count_o    (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]      n;
    logic [4:0][7:0] d;
    logic [4:0][1:0] l;
    logic [1:0]      e_cls;
    logic [7:0]      e_min;
    logic [1:0]      e_cnt;
  } vec_t;

  vec_t tv [7];

  function automatic vec_t mk(int n, int d0, int l0, int d1, int l1, int d2, int l2,
                              int d3, int l3, int d4, int l4, int c, int m, int k);
    vec_t v;
    v.n = 3'(n);
    v.d[0] = 8'(d0); v.l[0] = 2'(l0);
    v.d[1] = 8'(d1); v.l[1] = 2'(l1);
    v.d[2] = 8'(d2); v.l[2] = 2'(l2);
    v.d[3] = 8'(d3); v.l[3] = 2'(l3);
    v.d[4] = 8'(d4); v.l[4] = 2'(l4);
    v.e_cls = 2'(c);
    v.e_min = 8'(m);
    v.e_cnt = 2'(k);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic send(input int d, input int l, input bit lst);
    dist_i  = 8'(d);
    label_i = 2'(l);
    last_i  = lst;
    valid_i = 1'b1;
    @(negedge clk_i);
    chk("yumi_o on sample", int'(yumi_o), 1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Called just after the edge that accepted the last sample; counts edges until valid_o.
  task automatic wait_result(input string tag, input int c, input int m, input int k);
    int lat;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (valid_o) break;
    end
    chk({tag, " latency"}, lat, 5);
    chk({tag, " class_o"}, int'(class_o), c);
    chk({tag, " min_dist_o"}, int'(min_dist_o), m);
    chk({tag, " count_o"}, int'(count_o), k);
  endtask

  task automatic release_result(input string tag);
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    chk({tag, " valid_o after yumi_i"}, int'(valid_o), 0);
  endtask

  initial begin
    tv[0] = mk(5, 9,0, 4,1, 16,2, 1,1, 25,3, 1, 1, 3);   // basic ranking
    tv[1] = mk(3, 5,2, 5,0, 7,0, 0,0, 0,0,   0, 5, 3);   // equal distances keep arrival order
    tv[2] = mk(2, 8,2, 3,0, 0,0, 0,0, 0,0,   0, 3, 2);   // short query, 1/1 tie -> label 0
    tv[3] = mk(5, 1,2, 2,2, 3,1, 3,3, 200,3, 2, 1, 3);   // tie and far samples discarded
    tv[4] = mk(4, 6,3, 6,3, 6,1, 6,1, 0,0,   3, 6, 3);   // later equal samples must be dropped
    tv[5] = mk(2, 8,3, 9,2, 0,0, 0,0, 0,0,   2, 8, 2);   // 1/1 tie between labels 2 and 3
    tv[6] = mk(1, 255,1, 0,0, 0,0, 0,0, 0,0, 1, 255, 1); // single maximum-distance sample

    rst_i   = 1'b1;
    dist_i  = '0;
    label_i = '0;
    last_i  = 1'b0;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset valid_o", int'(valid_o), 0);
    chk("reset yumi_o", int'(yumi_o), 0);
    chk("reset class_o", int'(class_o), 0);
    chk("reset min_dist_o", int'(min_dist_o), 0);
    chk("reset count_o", int'(count_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int q = 0; q < 7; q++) begin
      for (int s = 0; s < int'(tv[q].n); s++)
        send(int'(tv[q].d[s]), int'(tv[q].l[s]), s == int'(tv[q].n) - 1);
      wait_result($sformatf("vec%0d", q), int'(tv[q].e_cls), int'(tv[q].e_min),
                  int'(tv[q].e_cnt));
      release_result($sformatf("vec%0d", q));
    end

    // Back-pressure: result held while upstream keeps offering a sample.
    send(7, 2, 1'b0);
    send(6, 2, 1'b1);
    wait_result("bp", 2, 6, 2);
    dist_i  = 8'd40;
    label_i = 2'd1;
    last_i  = 1'b1;
    valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o !== 1'b1 || yumi_o !== 1'b0 || class_o !== 2'd2 ||
          min_dist_o !== 8'd6 || count_o !== 2'd2)
        chk($sformatf("bp hold cycle %0d stable", c), 0, 1);
      else
        chk($sformatf("bp hold cycle %0d stable", c), 1, 1);
    end
    yumi_i = 1'b1;
    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    chk("bp valid_o after yumi_i", int'(valid_o), 0);
    chk("bp yumi_o one cycle after release", int'(yumi_o), 1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
    wait_result("bp next", 1, 40, 1);
    release_result("bp next");

    // Asynchronous reset while the vote is running.
    send(4, 1, 1'b0);
    send(5, 1, 1'b1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midvote valid_o", int'(valid_o), 0);
    chk("midvote yumi_o", int'(yumi_o), 0);
    chk("midvote class_o", int'(class_o), 0);
    chk("midvote min_dist_o", int'(min_dist_o), 0);
    chk("midvote count_o", int'(count_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send(2, 3, 1'b1);
    wait_result("post-reset", 3, 2, 1);
    release_result("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
